// File: rtl/adc_scan_tx.sv
// adc_scan_tx: scans N_CHAN multiplexed ADC channels and sends each sample
// as an asynchronous serial frame (start, DATA_W bits MSB first, stop).
// Optional feature macro: ADC_SCAN_TX_PARITY_EN inserts an even-parity bit
// before the stop bit.
module adc_scan_tx #(
   parameter int DATA_W   = 8,
   parameter int N_CHAN   = 8,
   parameter int BAUD_DIV = 105,
   localparam int CH_W    = (N_CHAN > 2) ? $clog2(N_CHAN) : 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              eoc,
   input  logic [DATA_W-1:0] data_in,
   input  logic              dsr,
   output logic              soc,
   output logic              load_dato,
   output logic              mux_en,
   output logic [CH_W-1:0]   canale,
   output logic              data_out,
   output logic              error,
   output logic              tx_end
);

`ifdef ADC_SCAN_TX_PARITY_EN
   localparam int N_BITS = DATA_W + 3;
`else
   localparam int N_BITS = DATA_W + 2;
`endif
   localparam int BIT_W = $clog2(N_BITS);
   localparam int CNT_W = $clog2(BAUD_DIV);

   typedef enum logic [2:0] {
      S_MUX, S_SETTLE, S_SOC, S_WAIT, S_LOAD, S_NEXT, S_SEND, S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic              capture;
   logic              start_req;
   logic              abort;
   logic              busy;
   logic [BIT_W-1:0]  bit_idx;
   logic [CNT_W-1:0]  baud_cnt;
   logic [DATA_W-1:0] shreg;
`ifdef ADC_SCAN_TX_PARITY_EN
   logic              par;
`endif

   assign capture   = (state == S_WAIT) && !eoc;
   assign start_req = (state == S_SEND);
   assign tx_end    = busy && (bit_idx == BIT_W'(N_BITS - 1))
                           && (baud_cnt == CNT_W'(BAUD_DIV - 1));

   // Scanner state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_MUX;
      else          state <= state_nxt;
   end

   // Scanner next-state: the only wait points are the ADC and the frame end
   always_comb begin
      state_nxt = state;
      case (state)
         S_MUX:    state_nxt = S_SETTLE;
         S_SETTLE: state_nxt = S_SOC;
         S_SOC:    state_nxt = S_WAIT;
         S_WAIT:   if (!eoc) state_nxt = S_LOAD;
         S_LOAD:   state_nxt = S_NEXT;
         S_NEXT:   state_nxt = S_SEND;
         S_SEND:   state_nxt = S_DONE;
         S_DONE:   if (tx_end || abort) state_nxt = S_MUX;
         default:  state_nxt = S_MUX;
      endcase
   end

   // Scanner outputs, registered so they hold across the states between set and clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         soc       <= 1'b0;
         load_dato <= 1'b0;
         mux_en    <= 1'b0;
         canale    <= '0;
      end else begin
         load_dato <= capture;
         if (state == S_MUX) mux_en <= 1'b1;
         if (capture)        mux_en <= 1'b0;
         if (state == S_SOC)  soc <= 1'b1;
         if (state == S_LOAD) soc <= 1'b0;
         if (state == S_NEXT)
            canale <= (canale == CH_W'(N_CHAN - 1)) ? '0 : canale + CH_W'(1);
      end
   end

   // Transmitter: sample capture, dsr handshake, baud timing and bit sequencing
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy     <= 1'b0;
         abort    <= 1'b0;
         error    <= 1'b0;
         data_out <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
`ifdef ADC_SCAN_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         abort <= 1'b0;
         // capture only happens while the line is idle, so no clash with shifting
         if (capture) begin
            shreg <= data_in;
`ifdef ADC_SCAN_TX_PARITY_EN
            par   <= ^data_in;
`endif
         end
         if (start_req) begin
            if (dsr) begin
               error    <= 1'b0;
               busy     <= 1'b1;
               data_out <= 1'b0;
               baud_cnt <= '0;
               bit_idx  <= '0;
            end else begin
               error <= 1'b1;
               abort <= 1'b1;
            end
         end else if (busy) begin
            if (baud_cnt == CNT_W'(BAUD_DIV - 1)) begin
               baud_cnt <= '0;
               if (bit_idx == BIT_W'(N_BITS - 1)) begin
                  busy     <= 1'b0;
                  bit_idx  <= '0;
                  data_out <= 1'b1;
               end else begin
                  bit_idx <= bit_idx + BIT_W'(1);
                  if (bit_idx < BIT_W'(DATA_W)) begin
                     data_out <= shreg[DATA_W-1];
                     shreg    <= shreg << 1;
                  end
`ifdef ADC_SCAN_TX_PARITY_EN
                  else if (bit_idx == BIT_W'(DATA_W)) data_out <= par;
`endif
                  else data_out <= 1'b1;
               end
            end else begin
               baud_cnt <= baud_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_scan_tx.sv
// Directed bench for adc_scan_tx (DATA_W=8, N_CHAN=5, BAUD_DIV=4).
// Parity scenario is built only when ADC_SCAN_TX_PARITY_EN is defined.
module tb_adc_scan_tx;
   logic       clock = 1'b0;
   logic       reset_n, eoc, dsr;
   logic [7:0] data_in;
   logic       soc, load_dato, mux_en, data_out, error, tx_end;
   logic [2:0] canale;
   int         passed = 0;
   int         total  = 0;

   always #5 clock = ~clock;

   adc_scan_tx #(.DATA_W(8), .N_CHAN(5), .BAUD_DIV(4)) dut (
      .clock(clock), .reset_n(reset_n), .eoc(eoc), .data_in(data_in), .dsr(dsr),
      .soc(soc), .load_dato(load_dato), .mux_en(mux_en), .canale(canale),
      .data_out(data_out), .error(error), .tx_end(tx_end)
   );

   // Expected line: each of nb frame bits (first at fr[nb-1]) held 4 cycles, then idle 1
   function automatic logic [63:0] exp_line(input logic [10:0] fr, input int nb);
      logic [63:0] l;
      for (int i = 0; i < 64; i++) l[i] = (i < 4*nb) ? fr[nb-1-i/4] : 1'b1;
      return l;
   endfunction

   // One scan: release the parked ADC wait, then record 64 cycles of the line
   task automatic do_scan(input logic [7:0] d, input logic dv,
                          output logic [63:0] line, output logic [63:0] tend,
                          output logic [2:0] ch, output logic [1:0] ld,
                          output logic e1, output logic to);
      int n;
      to = 1'b0; n = 0;
      while (soc !== 1'b1 && n < 200) begin @(negedge clock); n++; end
      if (soc !== 1'b1) to = 1'b1;
      data_in = d; dsr = dv; eoc = 1'b0;
      @(negedge clock); ld[0] = load_dato; eoc = 1'b1;
      @(negedge clock); ld[1] = load_dato;
      @(negedge clock); ch = canale;
      line = '1; tend = '0; e1 = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clock);
         line[i] = data_out; tend[i] = tx_end;
         if (i == 0) e1 = error;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; eoc = 1'b1; dsr = 1'b0; data_in = 8'h00;
      repeat (2) @(negedge clock);
      total++;
      if ({soc, load_dato, mux_en, canale, data_out, error, tx_end} !== 9'b000_000_100) begin
         $display("FAIL reset_outputs: got %b expected %b",
                  {soc, load_dato, mux_en, canale, data_out, error, tx_end}, 9'b000_000_100);
      end else passed++;
      reset_n = 1'b1;
      @(negedge clock);
      total++;
      if ({mux_en, soc} !== 2'b10) $display("FAIL reset_exit_mux: got %b expected 10", {mux_en, soc});
      else passed++;
      repeat (2) @(negedge clock);
      total++;
      if (soc !== 1'b1) $display("FAIL reset_reach_wait: soc got %b expected 1", soc);
      else passed++;
   endtask

   task automatic test_frame_a5();
      logic [63:0] line, tend; logic [2:0] ch; logic [1:0] ld; logic e1, to;
      logic [10:0] fr; int nb;
`ifdef ADC_SCAN_TX_PARITY_EN
      fr = 11'b01010010101; nb = 11;
`else
      fr = 11'b00101001011; nb = 10;
`endif
      do_scan(8'hA5, 1'b1, line, tend, ch, ld, e1, to);
      total++; if (to) $display("FAIL a5_timeout: soc never rose"); else passed++;
      total++; if (ld !== 2'b01) $display("FAIL a5_load_pulse: got %b expected 01", ld); else passed++;
      total++; if (ch !== 3'd1) $display("FAIL a5_canale: got %0d expected 1", ch); else passed++;
      total++;
      if (line !== exp_line(fr, nb)) $display("FAIL a5_line: got %h expected %h", line, exp_line(fr, nb));
      else passed++;
      total++;
      if (tend !== (64'd1 << (4*nb-1))) $display("FAIL a5_tx_end: got %h expected %h", tend, 64'd1 << (4*nb-1));
      else passed++;
      total++; if (e1 !== 1'b0) $display("FAIL a5_error: got %b expected 0", e1); else passed++;
   endtask

   task automatic test_reset_midframe();
      int n, bad;
      n = 0; bad = 0;
      while (soc !== 1'b1 && n < 200) begin @(negedge clock); n++; end
      total++; if (soc !== 1'b1) $display("FAIL rst_mid_timeout: soc never rose"); else passed++;
      data_in = 8'hA0; dsr = 1'b1; eoc = 1'b0;
      @(negedge clock); eoc = 1'b1;
      repeat (2) @(negedge clock);
      // frame cycles 21..24 carry data bit 3 (value 0 for 0xA0)
      repeat (22) @(negedge clock);
      total++;
      if ({data_out, canale} !== 4'b0_010) $display("FAIL rst_mid_pre: got %b expected 0010", {data_out, canale});
      else passed++;
      reset_n = 1'b0;
      #1;
      total++;
      if ({data_out, canale, tx_end} !== 5'b1_000_0)
         $display("FAIL rst_mid_immediate: got %b expected 10000", {data_out, canale, tx_end});
      else passed++;
      repeat (3) begin
         @(negedge clock);
         if (tx_end !== 1'b0 || data_out !== 1'b1 || soc !== 1'b0 || mux_en !== 1'b0) bad++;
      end
      reset_n = 1'b1;
      n = 0;
      while (soc !== 1'b1 && n < 20) begin
         @(negedge clock); n++;
         if (tx_end !== 1'b0 || data_out !== 1'b1) bad++;
      end
      total++; if (bad != 0) $display("FAIL rst_mid_quiet: got %0d bad cycles expected 0", bad); else passed++;
      total++;
      if ({soc, mux_en, canale, n[4:0]} !== {5'b11_000, 5'd3})
         $display("FAIL rst_mid_restart: got %b expected %b", {soc, mux_en, canale, n[4:0]}, {5'b11_000, 5'd3});
      else passed++;
   endtask

   task automatic test_canale_seq();
      logic [63:0] line, tend; logic [2:0] ch; logic [1:0] ld; logic e1, to;
      logic [2:0] exp_ch [6];
      exp_ch = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         do_scan(8'h10 + 8'(k), 1'b1, line, tend, ch, ld, e1, to);
         total++;
         if (to || ch !== exp_ch[k]) $display("FAIL canale_seq[%0d]: got %0d expected %0d (timeout=%b)", k, ch, exp_ch[k], to);
         else passed++;
      end
   endtask

   task automatic test_dsr_abort();
      logic [63:0] line, tend; logic [2:0] ch; logic [1:0] ld; logic e1, to;
      logic [10:0] fr; int nb;
`ifdef ADC_SCAN_TX_PARITY_EN
      fr = 11'b01100001101; nb = 11;
`else
      fr = 11'b00110000111; nb = 10;
`endif
      do_scan(8'h3C, 1'b0, line, tend, ch, ld, e1, to);
      total++; if (to) $display("FAIL abort_timeout: soc never rose"); else passed++;
      total++; if (line !== '1) $display("FAIL abort_line: got %h expected all ones", line); else passed++;
      total++; if (tend !== '0) $display("FAIL abort_tx_end: got %h expected 0", tend); else passed++;
      total++;
      if ({e1, error} !== 2'b11) $display("FAIL abort_error: got %b expected 11", {e1, error});
      else passed++;
      total++; if (soc !== 1'b1) $display("FAIL abort_rescan: soc got %b expected 1", soc); else passed++;
      do_scan(8'hC3, 1'b1, line, tend, ch, ld, e1, to);
      total++; if (e1 !== 1'b0) $display("FAIL abort_clear: error got %b expected 0", e1); else passed++;
      total++;
      if (line !== exp_line(fr, nb)) $display("FAIL abort_next_line: got %h expected %h", line, exp_line(fr, nb));
      else passed++;
   endtask

   task automatic test_eoc_hold();
      int n, bad;
      n = 0; bad = 0;
      while (soc !== 1'b1 && n < 200) begin @(negedge clock); n++; end
      eoc = 1'b1;
      repeat (50) begin
         @(negedge clock);
         if (soc !== 1'b1 || load_dato !== 1'b0 || mux_en !== 1'b1) bad++;
      end
      total++; if (bad != 0) $display("FAIL eoc_hold: got %0d bad cycles expected 0", bad); else passed++;
   endtask

`ifdef ADC_SCAN_TX_PARITY_EN
   task automatic test_parity();
      logic [63:0] line, tend; logic [2:0] ch; logic [1:0] ld; logic e1, to;
      do_scan(8'h07, 1'b1, line, tend, ch, ld, e1, to);
      total++;
      if (line !== exp_line(11'b00000011111, 11))
         $display("FAIL parity_line: got %h expected %h", line, exp_line(11'b00000011111, 11));
      else passed++;
      total++;
      if (tend !== (64'd1 << 43)) $display("FAIL parity_tx_end: got %h expected %h", tend, 64'd1 << 43);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_frame_a5();
      test_reset_midframe();
      test_canale_seq();
      test_dsr_abort();
      test_eoc_hold();
`ifdef ADC_SCAN_TX_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
